// File: rtl/bus_datapath_param_if.sv
// Bus-facing signal bundle of the parametrised single-bus datapath.
// The control unit drives it through 'master'; the datapath uses 'slave'.
interface bus_datapath_param_if #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16
);
    logic [NREG-1:0]  reg_in;
    logic [NREG-1:0]  reg_out;
    logic             pc_in;
    logic             ir_in;
    logic             y_in;
    logic             hi_in;
    logic             lo_in;
    logic             pc_out;
    logic             hi_out;
    logic             lo_out;
    logic             zhi_out;
    logic             zlo_out;
    logic             mdr_out;
    logic             inport_out;
    logic             inc_pc;
    logic             mdr_in;
    logic             read;
    logic [WIDTH-1:0] mdata_in;
    logic [WIDTH-1:0] inport_data;
    logic [3:0]       alu_op;
    logic             alu_start;
    logic             alu_busy;
    logic             alu_done;
    logic             div_by_zero;
    logic             bus_conflict;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] ir_q;

    modport master (
        output reg_in, reg_out, pc_in, ir_in, y_in, hi_in, lo_in,
        output pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out,
        output inc_pc, mdr_in, read, mdata_in, inport_data, alu_op, alu_start,
        input  alu_busy, alu_done, div_by_zero, bus_conflict, bus, ir_q
    );

    modport slave (
        input  reg_in, reg_out, pc_in, ir_in, y_in, hi_in, lo_in,
        input  pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out,
        input  inc_pc, mdr_in, read, mdata_in, inport_data, alu_op, alu_start,
        output alu_busy, alu_done, div_by_zero, bus_conflict, bus, ir_q
    );
endinterface

// File: rtl/bus_datapath_param.sv
// Parametrised single-bus CPU datapath: register file, PC/IR/Y/HI/LO/MDR, Z pair,
// single-cycle ALU plus an iterative signed multiplier/divider.
module bus_datapath_param #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16
) (
    input logic                 clk,
    input logic                 clr,
    bus_datapath_param_if.slave dp
);
    localparam int LOGW = $clog2(WIDTH);
    localparam int NSRC = NREG + 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    logic [WIDTH-1:0] gpr_r [NREG];
    logic [WIDTH-1:0] pc_r, ir_r, y_r, hi_r, lo_r, mdr_r, zhi_r, zlo_r;

    alu_state_t       state_r, state_nxt_s;
    logic [LOGW-1:0]  cnt_r;
    logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opnd_r;
    logic             is_div_r, neg_q_r, neg_r_r;
    logic             busy_r, done_r, dbz_r;

    logic [NSRC-1:0]  sel_s;
    logic [WIDTH-1:0] src_s [NSRC];
    logic [WIDTH-1:0] bus_s;
    logic             conflict_s;

    logic             start_s, iter_s, dz_s, last_s;
    logic [WIDTH:0]   mul_sum_s, div_sh_s;
    logic [WIDTH-1:0] div_diff_s, hi_nxt_s, lo_nxt_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            mag = -v;
        end else begin
            mag = v;
        end
    endfunction

    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [LOGW-1:0]    sh;
        logic [2*WIDTH-1:0] ror_t, rol_t;
        sh    = b[LOGW-1:0];
        ror_t = {a, a} >> sh;
        rol_t = {a, a} << sh;
        case (op)
            4'd0:    alu_single = a + b;
            4'd1:    alu_single = a - b;
            4'd2:    alu_single = a & b;
            4'd3:    alu_single = a | b;
            4'd4:    alu_single = ~b;
            4'd5:    alu_single = -b;
            4'd6:    alu_single = a << sh;
            4'd7:    alu_single = a >> sh;
            4'd8:    alu_single = $signed(a) >>> sh;
            4'd9:    alu_single = ror_t[WIDTH-1:0];
            4'd10:   alu_single = rol_t[2*WIDTH-1:WIDTH];
            default: alu_single = {WIDTH{1'b0}};
        endcase
    endfunction

    // Gather bus drive selects and candidate sources, index 0 = highest priority
    always_comb begin
        sel_s = {dp.inport_out, dp.mdr_out, dp.pc_out, dp.zlo_out, dp.zhi_out,
                 dp.lo_out, dp.hi_out, dp.reg_out};
        for (int i = 0; i < NREG; i++) begin
            src_s[i] = gpr_r[i];
        end
        src_s[NREG]     = hi_r;
        src_s[NREG + 1] = lo_r;
        src_s[NREG + 2] = zhi_r;
        src_s[NREG + 3] = zlo_r;
        src_s[NREG + 4] = pc_r;
        src_s[NREG + 5] = mdr_r;
        src_s[NREG + 6] = dp.inport_data;
    end

    // Priority bus mux; scanning low priority first lets the winner overwrite
    always_comb begin
        bus_s = {WIDTH{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            bus_s = sel_s[i] ? src_s[i] : bus_s;
        end
        conflict_s = |(sel_s & (sel_s - NSRC'(1'b1)));
    end

    assign dp.bus          = bus_s;
    assign dp.bus_conflict = conflict_s;
    assign dp.ir_q         = ir_r;
    assign dp.alu_busy     = busy_r;
    assign dp.alu_done     = done_r;
    assign dp.div_by_zero  = dbz_r;

    // Programmer-visible registers, all loaded from the pre-edge bus value
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_r[i] <= {WIDTH{1'b0}};
            end
            pc_r  <= {WIDTH{1'b0}};
            ir_r  <= {WIDTH{1'b0}};
            y_r   <= {WIDTH{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
            lo_r  <= {WIDTH{1'b0}};
            mdr_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (dp.reg_in[i]) begin
                    gpr_r[i] <= bus_s;
                end
            end
            if (dp.pc_in) begin
                pc_r <= bus_s;
            end else if (dp.inc_pc) begin
                pc_r <= pc_r + WIDTH'(1'b1);
            end
            if (dp.ir_in) ir_r <= bus_s;
            if (dp.y_in)  y_r  <= bus_s;
            if (dp.hi_in) hi_r <= bus_s;
            if (dp.lo_in) lo_r <= bus_s;
            if (dp.mdr_in) begin
                mdr_r <= dp.read ? dp.mdata_in : bus_s;
            end
        end
    end

    // ALU request decode and one iteration step of multiply/divide
    always_comb begin
        start_s = dp.alu_start && (state_r == ST_IDLE);
        iter_s  = (dp.alu_op == 4'd11) || (dp.alu_op == 4'd12);
        dz_s    = (dp.alu_op == 4'd12) && (bus_s == {WIDTH{1'b0}});
        last_s  = (cnt_r == LOGW'(WIDTH - 1));

        mul_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_sh_s   = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s = div_sh_s[WIDTH-1:0] - opnd_r;

        if (is_div_r) begin
            if (div_sh_s >= {1'b0, opnd_r}) begin
                hi_nxt_s = div_diff_s;
                lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_s = div_sh_s[WIDTH-1:0];
                lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = mul_sum_s[WIDTH:1];
            lo_nxt_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end

        prod_fix_s = neg_q_r ? -{hi_nxt_s, lo_nxt_s} : {hi_nxt_s, lo_nxt_s};
        quo_fix_s  = neg_q_r ? -lo_nxt_s : lo_nxt_s;
        rem_fix_s  = neg_r_r ? -hi_nxt_s : hi_nxt_s;
    end

    // ALU sequencing: single-cycle and divide-by-zero go straight to DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && iter_s && !dz_s) begin
                    state_nxt_s = ST_RUN;
                end else if (start_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state plus registered busy/done flags derived from the next state
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Z registers, operand capture and the iterative accumulator
    always_ff @(posedge clk) begin
        if (!clr) begin
            zhi_r    <= {WIDTH{1'b0}};
            zlo_r    <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            cnt_r    <= {LOGW{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            dbz_r <= 1'b0;
            if (start_s) begin
                if (!iter_s) begin
                    zlo_r <= alu_single(dp.alu_op, y_r, bus_s);
                    zhi_r <= {WIDTH{1'b0}};
                end else if (dz_s) begin
                    zlo_r <= {WIDTH{1'b1}};
                    zhi_r <= y_r;
                    dbz_r <= 1'b1;
                end else begin
                    // Work on magnitudes; signs are reapplied on the final step
                    is_div_r <= (dp.alu_op == 4'd12);
                    neg_q_r  <= y_r[WIDTH-1] ^ bus_s[WIDTH-1];
                    neg_r_r  <= y_r[WIDTH-1];
                    acc_hi_r <= {WIDTH{1'b0}};
                    cnt_r    <= {LOGW{1'b0}};
                    if (dp.alu_op == 4'd12) begin
                        opnd_r   <= mag(bus_s);
                        acc_lo_r <= mag(y_r);
                    end else begin
                        opnd_r   <= mag(y_r);
                        acc_lo_r <= mag(bus_s);
                    end
                end
            end else if (state_r == ST_RUN) begin
                acc_hi_r <= hi_nxt_s;
                acc_lo_r <= lo_nxt_s;
                cnt_r    <= cnt_r + LOGW'(1'b1);
                if (last_s) begin
                    if (is_div_r) begin
                        zlo_r <= quo_fix_s;
                        zhi_r <= rem_fix_s;
                    end else begin
                        {zhi_r, zlo_r} <= prod_fix_s;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_datapath_param.sv
// Randomised self-checking bench for bus_datapath_param against an arithmetic model.
module tb_bus_datapath_param;
    logic clk;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] m_z = 64'd0;

    bus_datapath_param_if #(.WIDTH(32), .NREG(16)) dif ();

    bus_datapath_param #(.WIDTH(32), .NREG(16)) dut (
        .clk(clk),
        .clr(clr),
        .dp (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU: returns {Z_HI, Z_LO}
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int          s;
        longint      sa, sb, q, m;
        s  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = ~b;
            4'd5:  r = 32'd0 - b;
            4'd6:  r = a << s;
            4'd7:  r = a >> s;
            4'd8:  r = $signed(a) >>> s;
            4'd9:  r = (a >> s) | (a << (32 - s));
            4'd10: r = (a << s) | (a >> (32 - s));
            4'd11: return sa * sb;
            4'd12: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                m = sa % sb;
                return {m[31:0], q[31:0]};
            end
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic clear_ctl();
        dif.reg_in = '0;  dif.reg_out = '0;
        dif.pc_in = 1'b0; dif.ir_in = 1'b0; dif.y_in = 1'b0; dif.hi_in = 1'b0; dif.lo_in = 1'b0;
        dif.pc_out = 1'b0; dif.hi_out = 1'b0; dif.lo_out = 1'b0; dif.zhi_out = 1'b0;
        dif.zlo_out = 1'b0; dif.mdr_out = 1'b0; dif.inport_out = 1'b0;
        dif.inc_pc = 1'b0; dif.mdr_in = 1'b0; dif.read = 1'b0; dif.alu_start = 1'b0;
        dif.alu_op = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] v);
        dif.inport_data = v;
        dif.inport_out  = 1'b1;
    endtask

    // Source index: 0..15 R, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort
    task automatic apply_sel(input logic [22:0] s);
        dif.reg_out    = s[15:0];
        dif.hi_out     = s[16];
        dif.lo_out     = s[17];
        dif.zhi_out    = s[18];
        dif.zlo_out    = s[19];
        dif.pc_out     = s[20];
        dif.mdr_out    = s[21];
        dif.inport_out = s[22];
    endtask

    task automatic peek(input int src, output logic [31:0] v);
        apply_sel(23'd1 << src);
        #1;
        v = dif.bus;
        apply_sel(23'd0);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int poke_at);
        logic [63:0] exp;
        logic [31:0] v;
        int          cyc;
        bit          iter;
        bit          dz;
        exp  = ref_alu(op, a, b);
        dz   = (op == 4'd12) && (b == 32'd0);
        iter = ((op == 4'd11) || (op == 4'd12)) && !dz;
        put(a); dif.y_in = 1'b1; tick(); clear_ctl();
        put(b); dif.alu_op = op; dif.alu_start = 1'b1; tick(); clear_ctl();
        cyc = 0;
        while (dif.alu_busy && cyc < 200) begin
            cyc++;
            if (cyc == poke_at) begin
                put(32'd1); dif.alu_op = 4'd0; dif.alu_start = 1'b1;
            end
            tick();
            clear_ctl();
        end
        check_eq({tag, " busy_cycles"}, 64'(cyc), iter ? 64'd32 : 64'd0);
        check_eq({tag, " done"}, 64'(dif.alu_done), 64'd1);
        check_eq({tag, " dbz"}, 64'(dif.div_by_zero), dz ? 64'd1 : 64'd0);
        peek(19, v); check_eq({tag, " z_lo"}, 64'(v), 64'(exp[31:0]));
        peek(18, v); check_eq({tag, " z_hi"}, 64'(v), 64'(exp[63:32]));
        tick();
        check_eq({tag, " done_drop"}, 64'(dif.alu_done), 64'd0);
        m_z = exp;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] m_src [23];
        logic [22:0] s;
        int          exp_idx;
        int          nsel;
        bit          seen;

        clr = 1'b0;
        dif.inport_data = 32'd0;
        dif.mdata_in    = 32'd0;
        clear_ctl();
        tick(); tick();
        clr = 1'b1;
        tick();

        // Reset with every strobe asserted
        put(32'h1234); dif.reg_in[5] = 1'b1; tick(); clear_ctl();
        put(32'd9); dif.pc_in = 1'b1; tick(); clear_ctl();
        peek(5, v); check_eq("preload_r5", 64'(v), 64'h1234);
        clr = 1'b0;
        dif.reg_in = '1; dif.reg_out = '1; dif.pc_in = 1'b1; dif.ir_in = 1'b1; dif.y_in = 1'b1;
        dif.hi_in = 1'b1; dif.lo_in = 1'b1; dif.mdr_in = 1'b1; dif.inc_pc = 1'b1;
        apply_sel('1); put(32'hDEAD_BEEF); dif.alu_op = 4'd11; dif.alu_start = 1'b1;
        tick();
        clr = 1'b1; clear_ctl(); #1;
        check_eq("rst_bus_idle", 64'(dif.bus), 64'd0);
        check_eq("rst_conflict", 64'(dif.bus_conflict), 64'd0);
        check_eq("rst_busy", 64'(dif.alu_busy), 64'd0);
        check_eq("rst_done", 64'(dif.alu_done), 64'd0);
        check_eq("rst_dbz", 64'(dif.div_by_zero), 64'd0);
        check_eq("rst_ir", 64'(dif.ir_q), 64'd0);
        for (int i = 0; i < 22; i++) begin
            peek(i, v);
            check_eq($sformatf("rst_src%0d", i), 64'(v), 64'd0);
        end

        // ADD through the register file
        put(32'd5); dif.reg_in[2] = 1'b1; tick(); clear_ctl();
        put(32'd7); dif.reg_in[3] = 1'b1; tick(); clear_ctl();
        dif.reg_out[3] = 1'b1; dif.y_in = 1'b1; tick(); clear_ctl();
        dif.reg_out[2] = 1'b1; dif.alu_op = 4'd0; dif.alu_start = 1'b1; tick(); clear_ctl();
        check_eq("add_done", 64'(dif.alu_done), 64'd1);
        check_eq("add_busy", 64'(dif.alu_busy), 64'd0);
        peek(19, v); check_eq("add_zlo", 64'(v), 64'd12);
        peek(18, v); check_eq("add_zhi", 64'(v), 64'd0);
        tick();
        check_eq("add_done_drop", 64'(dif.alu_done), 64'd0);

        // IR and MDR loads
        put(32'hA5A5_0F0F); dif.ir_in = 1'b1; tick(); clear_ctl();
        check_eq("ir_load", 64'(dif.ir_q), 64'hA5A5_0F0F);
        put(32'h0BAD_CAFE); dif.mdr_in = 1'b1; tick(); clear_ctl();
        peek(21, v); check_eq("mdr_from_bus", 64'(v), 64'h0BAD_CAFE);

        // Directed multiply/divide cases, with a stray start mid-multiply
        run_op(4'd11, 32'hFFFF_FFFA, 32'd7, "mul_neg6x7", 5);
        run_op(4'd12, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", -1);
        run_op(4'd12, 32'd5, 32'd0, "div_by_zero", -1);

        // Bus conflict and PC update priority / wrap
        put(32'd3); dif.reg_in[1] = 1'b1; tick(); clear_ctl();
        put(32'd8); dif.pc_in = 1'b1; tick(); clear_ctl();
        dif.reg_out[1] = 1'b1; dif.pc_out = 1'b1; #1;
        check_eq("conflict_bus", 64'(dif.bus), 64'd3);
        check_eq("conflict_flag", 64'(dif.bus_conflict), 64'd1);
        dif.pc_in = 1'b1; dif.inc_pc = 1'b1; tick(); clear_ctl();
        peek(20, v); check_eq("pc_in_over_inc", 64'(v), 64'd3);
        put(32'hFFFF_FFFF); dif.pc_in = 1'b1; tick(); clear_ctl();
        dif.inc_pc = 1'b1; tick(); clear_ctl();
        peek(20, v); check_eq("pc_wrap", 64'(v), 64'd0);

        // Reset in the middle of a multiply
        put(32'd1234); dif.y_in = 1'b1; tick(); clear_ctl();
        put(32'd77); dif.alu_op = 4'd11; dif.alu_start = 1'b1; tick(); clear_ctl();
        repeat (9) tick();
        check_eq("midmul_busy_before", 64'(dif.alu_busy), 64'd1);
        clr = 1'b0; tick(); clr = 1'b1;
        check_eq("midmul_busy_after", 64'(dif.alu_busy), 64'd0);
        peek(19, v); check_eq("midmul_zlo", 64'(v), 64'd0);
        peek(18, v); check_eq("midmul_zhi", 64'(v), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (dif.alu_done) seen = 1'b1;
        end
        check_eq("midmul_no_done", 64'(seen), 64'd0);

        // Random ALU operations
        for (int n = 0; n < 30; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(0, 10)) - 32'd5; end
                2: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, $sformatf("rnd%0d_op%0d", n, op), -1);
        end

        // Random bus source priority and conflict detection
        for (int i = 0; i < 16; i++) begin
            m_src[i] = $urandom;
            put(m_src[i]); dif.reg_in[i] = 1'b1; tick(); clear_ctl();
        end
        m_src[16] = $urandom; put(m_src[16]); dif.hi_in = 1'b1; tick(); clear_ctl();
        m_src[17] = $urandom; put(m_src[17]); dif.lo_in = 1'b1; tick(); clear_ctl();
        m_src[18] = m_z[63:32];
        m_src[19] = m_z[31:0];
        m_src[20] = $urandom; put(m_src[20]); dif.pc_in = 1'b1; tick(); clear_ctl();
        m_src[21] = $urandom;
        dif.mdata_in = m_src[21]; dif.read = 1'b1; dif.mdr_in = 1'b1; tick(); clear_ctl();
        m_src[22] = $urandom;
        dif.inport_data = m_src[22];
        for (int n = 0; n < 25; n++) begin
            for (int j = 0; j < 23; j++) s[j] = ($urandom_range(0, 9) == 0);
            exp_idx = -1;
            nsel    = 0;
            for (int j = 0; j < 23; j++) begin
                if (s[j]) begin
                    nsel++;
                    if (exp_idx < 0) exp_idx = j;
                end
            end
            apply_sel(s); #1;
            check_eq($sformatf("bus_rnd%0d", n), 64'(dif.bus),
                     (exp_idx < 0) ? 64'd0 : 64'(m_src[exp_idx]));
            check_eq($sformatf("conflict_rnd%0d", n), 64'(dif.bus_conflict),
                     (nsel >= 2) ? 64'd1 : 64'd0);
            apply_sel(23'd0); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
